// File: rtl/cfg_bank_pkg.sv
// Shared types and helpers for the run-time configuration value bank.
package cfg_bank_pkg;

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  // Address width for n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cfg_bank_channel.sv
// One configuration channel: a software-written staging register and the
// active register that is loaded from staging when its turn in a commit comes.
module cfg_bank_channel #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DEFAULT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             cp_en,
  output logic [WIDTH-1:0] active
);

  logic [WIDTH-1:0] staging;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      staging <= DEFAULT;
      active  <= DEFAULT;
    end else begin
      if (wr_en) staging <= wr_data;
      if (cp_en) active  <= staging;
    end
  end

endmodule

// File: rtl/cfg_value_bank.sv
// Bank of NUM_CH run-time parameter values: staged writes, sequential
// staging->active commit, registered reads of the active copy.
module cfg_value_bank
  import cfg_bank_pkg::*;
#(
  parameter int                      NUM_CH   = 4,
  parameter int                      WIDTH    = 32,
  parameter logic [NUM_CH*WIDTH-1:0] DEFAULTS = '0,
  localparam int                     AW       = clog2_min1(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  output logic                    wr_err,
  input  logic                    commit,
  output logic                    commit_busy,
  output logic                    commit_done,
  output logic                    commit_ovr,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  output logic                    rd_err,
  output logic [NUM_CH*WIDTH-1:0] active_values
);

  state_t           state, state_nx;
  logic [AW-1:0]    cnt, cnt_nx;
  logic             wr_fire;
  logic             wr_in_range;
  logic             rd_in_range;
  logic             cnt_last;
  logic [WIDTH-1:0] act [NUM_CH];
  logic [WIDTH-1:0] rd_mux;

  assign commit_busy = (state != IDLE);
  assign commit_done = (state == DONE);
  assign wr_ready    = ~commit_busy;
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_in_range = int'(wr_addr) < NUM_CH;
  assign rd_in_range = int'(rd_addr) < NUM_CH;
  assign cnt_last    = (cnt == AW'(NUM_CH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (commit) begin
        state_nx = COPY;
        cnt_nx   = '0;
      end
      COPY: if (cnt_last) begin
        state_nx = DONE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + AW'(1);
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // wr_ready is low outside IDLE, so staging is frozen for the whole transfer.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cfg_bank_channel #(
      .WIDTH   (WIDTH),
      .DEFAULT (DEFAULTS[i*WIDTH +: WIDTH])
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_fire && (wr_addr == AW'(i))),
      .wr_data (wr_data),
      .cp_en   ((state == COPY) && (cnt == AW'(i))),
      .active  (act[i])
    );
    assign active_values[i*WIDTH +: WIDTH] = act[i];
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_addr == AW'(i)) rd_mux = act[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_err     <= 1'b0;
      commit_ovr <= 1'b0;
      rd_valid   <= 1'b0;
      rd_err     <= 1'b0;
      rd_data    <= '0;
    end else begin
      wr_err     <= wr_fire & ~wr_in_range;
      commit_ovr <= commit & commit_busy;
      rd_valid   <= rd_en;
      rd_err     <= rd_en & ~rd_in_range;
      if (rd_en) rd_data <= rd_in_range ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_cfg_value_bank.sv
// Directed self-checking bench for cfg_value_bank: a 4x8 bank and a 1x8 bank.
module tb_cfg_value_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Bank A: NUM_CH=4, WIDTH=8; ch0=5 ch1=7 ch2=9 ch3=15
  localparam logic [31:0] A_DEF = {8'd15, 8'd9, 8'd7, 8'd5};
  logic        a_wr_valid, a_wr_ready, a_wr_err;
  logic [1:0]  a_wr_addr, a_rd_addr;
  logic [7:0]  a_wr_data, a_rd_data;
  logic        a_commit, a_busy, a_done, a_ovr;
  logic        a_rd_en, a_rd_valid, a_rd_err;
  logic [31:0] a_vals;

  cfg_value_bank #(.NUM_CH(4), .WIDTH(8), .DEFAULTS(A_DEF)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .wr_err(a_wr_err),
    .commit(a_commit), .commit_busy(a_busy), .commit_done(a_done), .commit_ovr(a_ovr),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .rd_err(a_rd_err), .active_values(a_vals)
  );

  // Bank B: NUM_CH=1, WIDTH=8, default 0xA5; address 1 is out of range
  logic       b_wr_valid, b_wr_ready, b_wr_err;
  logic [0:0] b_wr_addr, b_rd_addr;
  logic [7:0] b_wr_data, b_rd_data;
  logic       b_commit, b_busy, b_done, b_ovr;
  logic       b_rd_en, b_rd_valid, b_rd_err;
  logic [7:0] b_vals;

  cfg_value_bank #(.NUM_CH(1), .WIDTH(8), .DEFAULTS(8'hA5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_err(b_wr_err),
    .commit(b_commit), .commit_busy(b_busy), .commit_done(b_done), .commit_ovr(b_ovr),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .rd_err(b_rd_err), .active_values(b_vals)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks up to max_cyc cycles, reporting the first cycle with commit_done and the pulse count.
  task automatic run_copy(input bit sel_b, input int max_cyc, output int first, output int count);
    first = 0;
    count = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      tick();
      if (sel_b ? b_done : a_done) begin
        count++;
        if (first == 0) first = k;
      end
    end
  endtask

  int first, count;

  initial begin
    rst_n = 1'b0;
    a_wr_valid = 0; a_wr_addr = 0; a_wr_data = 0; a_commit = 0; a_rd_en = 0; a_rd_addr = 0;
    b_wr_valid = 0; b_wr_addr = 0; b_wr_data = 0; b_commit = 0; b_rd_en = 0; b_rd_addr = 0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_active", a_vals, A_DEF);
    check("rst_busy", a_busy, 0);
    check("rst_wr_ready", a_wr_ready, 1);
    check("rst_rd_valid", a_rd_valid, 0);
    check("rst_done", a_done, 0);

    // Read ch1: default 7, one cycle latency
    a_rd_en = 1; a_rd_addr = 1;
    tick();
    a_rd_en = 0;
    check("rd1_valid", a_rd_valid, 1);
    check("rd1_data", a_rd_data, 7);
    tick();
    check("rd1_valid_drop", a_rd_valid, 0);

    // Stage ch0=32, ch1=33 without commit
    a_wr_valid = 1; a_wr_addr = 0; a_wr_data = 32;
    tick();
    a_wr_addr = 1; a_wr_data = 33;
    tick();
    a_wr_valid = 0;
    a_rd_en = 1; a_rd_addr = 0;
    tick();
    a_rd_en = 0;
    check("staged_rd0", a_rd_data, 5);
    check("staged_active", a_vals, A_DEF);

    // Commit; read ch0 in the cycle it is copied returns the old value
    a_commit = 1;
    tick();
    a_commit = 0;
    check("busy_copy", a_busy, 1);
    a_rd_en = 1; a_rd_addr = 0;
    tick();
    a_rd_en = 0;
    check("rd_old", a_rd_data, 5);
    check("ch0_copied", a_vals[7:0], 32);
    check("done_early", a_done, 0);
    run_copy(1'b0, 8, first, count);
    check("done_latency", first + 1, 4);
    check("done_count", count, 1);
    check("busy_idle", a_busy, 0);
    a_rd_en = 1; a_rd_addr = 0;
    tick();
    a_rd_en = 0;
    check("commit_rd0", a_rd_data, 32);
    check("commit_vals", a_vals, {8'd15, 8'd9, 8'd33, 8'd32});

    // Write ch3=99 with commit in the same cycle; blocked write and dropped commit during COPY
    a_wr_valid = 1; a_wr_addr = 3; a_wr_data = 99; a_commit = 1;
    tick();
    a_wr_addr = 2; a_wr_data = 77;
    check("wr_ready_busy", a_wr_ready, 0);
    tick();
    a_wr_valid = 0; a_commit = 0;
    check("ovr_pulse", a_ovr, 1);
    count = (a_done) ? 1 : 0;
    tick();
    check("ovr_drop", a_ovr, 0);
    if (a_done) count++;
    begin
      int c2;
      run_copy(1'b0, 8, first, c2);
      count += c2;
    end
    check("single_done", count, 1);
    check("ch3_included", a_vals[31:24], 99);
    check("ch2_unwritten", a_vals[23:16], 9);

    // Reset in the middle of a transfer
    a_commit = 1;
    tick();
    a_commit = 0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_active", a_vals, A_DEF);
    check("abort_busy", a_busy, 0);
    run_copy(1'b0, 6, first, count);
    check("abort_no_done", count, 0);
    a_commit = 1;
    tick();
    a_commit = 0;
    run_copy(1'b0, 8, first, count);
    check("abort_staging", a_vals, A_DEF);

    // Single-channel bank: out-of-range write and read
    b_wr_valid = 1; b_wr_addr = 1; b_wr_data = 8'h3C;
    tick();
    b_wr_valid = 0;
    check("b_wr_err", b_wr_err, 1);
    tick();
    check("b_wr_err_drop", b_wr_err, 0);
    b_rd_en = 1; b_rd_addr = 1;
    tick();
    check("b_rd_err", b_rd_err, 1);
    check("b_rd_err_data", b_rd_data, 0);
    check("b_rd_err_valid", b_rd_valid, 1);
    b_rd_addr = 0;
    tick();
    b_rd_en = 0;
    check("b_rd0", b_rd_data, 8'hA5);
    check("b_rd0_err", b_rd_err, 0);
    b_commit = 1;
    tick();
    b_commit = 0;
    check("b_busy", b_busy, 1);
    run_copy(1'b1, 6, first, count);
    check("b_done_latency", first, 1);
    check("b_done_count", count, 1);
    check("b_staging_kept", b_vals, 8'hA5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
